ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder.sv | 150 +++++++++++++++
 tb/tb_ram_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// ram_responder: single-port 32-bit word RAM behind a read/write handshake.
// A request sampled in IDLE is latched, held for LATENCY wait states, and
// completes with a one-cycle mem_ready pulse in RESP.
// Optional build macro: RAM_RESPONDER_BOUNDS_EN (out-of-range address check).
//
// state | meaning
// IDLE  | no request in flight; mem_read/mem_write sampled every edge
// WAIT  | request latched; count runs down the remaining wait states
// RESP  | array access done on entry; mem_ready high for this one cycle
module ram_responder #(
    parameter int LATENCY = 2,
    parameter int AW      = 9
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] Maddrout,
    input  logic [31:0] Mdataout,
    output logic [31:0] Mdatain,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        addr_err
);

    localparam int         DEPTH = 1 << AW;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mdatain_q, mdatain_d;
    logic        err_q, err_d;

    logic          enter_resp;
    logic          oob;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic          mem_we;

    logic [31:0] mem_q [0:DEPTH-1];

    // Next-state logic: accept in IDLE, count down in WAIT, always leave RESP.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    // write wins when both are requested
                    wr_d    = mem_write;
                    addr_d  = Maddrout;
                    wdata_d = Mdataout;
                    count_d = LAT;
                    if (LAT == 4'd0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The *_d copies of the transaction already equal the latched values on
    // any edge entering RESP, including the zero-latency accept edge.
    assign idx     = addr_d[AW-1:0];
    assign rd_word = mem_q[idx];

`ifdef RAM_RESPONDER_BOUNDS_EN
    assign oob = |addr_d[31:AW];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_d[31:AW];
    assign oob            = 1'b0;
`endif

    // The array has no reset, so hold off writes while clear is low; that
    // keeps a zero-latency request presented during reset from landing.
    assign mem_we = enter_resp & wr_d & ~oob & clear;

    // Read data and error flag are captured on the edge entering RESP.
    always_comb begin
        mdatain_d = mdatain_q;
        if (enter_resp && !wr_d) begin
            mdatain_d = oob ? 32'h0 : rd_word;
        end
        err_d = enter_resp & oob;
    end

    // Control and transaction registers with asynchronous clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            wr_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            mdatain_q <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mdatain_q <= mdatain_d;
            err_q     <= err_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_d;
        end
    end

    assign Mdatain   = mdatain_q;
    assign mem_ready = (state_q == RESP);
    assign mem_busy  = (state_q != IDLE);
    assign addr_err  = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_ram_responder;

    logic        clock = 1'b0;
    logic        clear = 1'b0;

    logic        rd2 = 1'b0, wr2 = 1'b0;
    logic [31:0] addr2 = 32'h0, data2 = 32'h0;
    logic [31:0] din2;
    logic        rdy2, busy2, err2;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr0 = 32'h0, data0 = 32'h0;
    logic [31:0] din0;
    logic        rdy0, busy0, err0;

    int compared   = 0;
    int mismatched = 0;

`ifdef RAM_RESPONDER_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    always #5 clock = ~clock;

    ram_responder #(.LATENCY(2), .AW(9)) dut2 (
        .clock(clock), .clear(clear),
        .mem_read(rd2), .mem_write(wr2),
        .Maddrout(addr2), .Mdataout(data2),
        .Mdatain(din2), .mem_ready(rdy2), .mem_busy(busy2), .addr_err(err2)
    );

    ram_responder #(.LATENCY(0), .AW(9)) dut0 (
        .clock(clock), .clear(clear),
        .mem_read(rd0), .mem_write(wr0),
        .Maddrout(addr0), .Mdataout(data0),
        .Mdatain(din0), .mem_ready(rdy0), .mem_busy(busy0), .addr_err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full LATENCY=2 transaction with cycle-accurate handshake checks.
    task automatic do2(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
        rd2 = r; wr2 = w; addr2 = a; data2 = d;
        tick();
        rd2 = 1'b0; wr2 = 1'b0;
        chk({tag, " busy@acc"}, 32'(busy2), 32'd1);
        chk({tag, " rdy@acc"}, 32'(rdy2), 32'd0);
        tick();
        chk({tag, " rdy@+2"}, 32'(rdy2), 32'd0);
        tick();
        chk({tag, " rdy@+3"}, 32'(rdy2), 32'd1);
        tick();
        chk({tag, " rdy@+4"}, 32'(rdy2), 32'd0);
        chk({tag, " busy@+4"}, 32'(busy2), 32'd0);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst din", din2, 32'h0);
        chk("rst rdy", 32'(rdy2), 32'd0);
        chk("rst busy", 32'(busy2), 32'd0);
        chk("rst err", 32'(err2), 32'd0);
        chk("rst busy0", 32'(busy0), 32'd0);
        @(negedge clock);
        clear = 1'b1;
        tick();

        // write then read back at LATENCY=2
        do2(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, "wr5");
        chk("wr5 din", din2, 32'h0);
        do2(1'b1, 1'b0, 32'd5, 32'h0, "rd5");
        chk("rd5 din", din2, 32'hDEADBEEF);

        // mid-flight address/data/request changes are ignored
        do2(1'b0, 1'b1, 32'd8, 32'h88, "wr8");
        wr2 = 1'b1; addr2 = 32'd7; data2 = 32'h1;
        tick();
        wr2 = 1'b0; addr2 = 32'd8; data2 = 32'h2;
        tick();
        wr2 = 1'b1;
        tick();
        wr2 = 1'b0;
        chk("wr7 rdy", 32'(rdy2), 32'd1);
        tick();
        chk("wr7 no requeue", 32'(busy2), 32'd0);
        do2(1'b1, 1'b0, 32'd8, 32'h0, "rd8");
        chk("rd8 din", din2, 32'h88);
        do2(1'b1, 1'b0, 32'd7, 32'h0, "rd7");
        chk("rd7 din", din2, 32'h1);

        // read and write together: write wins, Mdatain untouched
        do2(1'b1, 1'b1, 32'd3, 32'hA5A5A5A5, "both3");
        chk("both3 din", din2, 32'h1);
        do2(1'b1, 1'b0, 32'd3, 32'h0, "rd3");
        chk("rd3 din", din2, 32'hA5A5A5A5);

        // reset in WAIT aborts the write
        do2(1'b0, 1'b1, 32'd9, 32'h99, "wr9");
        wr2 = 1'b1; addr2 = 32'd9; data2 = 32'h55;
        tick();
        wr2 = 1'b0;
        tick();
        #2;
        clear = 1'b0;
        #1;
        chk("abort rdy", 32'(rdy2), 32'd0);
        chk("abort busy", 32'(busy2), 32'd0);
        chk("abort din", din2, 32'h0);
        tick();
        tick();
        chk("abort rdy late", 32'(rdy2), 32'd0);
        clear = 1'b1;
        rd2 = 1'b1; addr2 = 32'd9;
        tick();
        rd2 = 1'b0;
        chk("post-rst accept", 32'(busy2), 32'd1);
        tick();
        tick();
        chk("rd9 rdy", 32'(rdy2), 32'd1);
        chk("rd9 din", din2, 32'h99);
        tick();

        // LATENCY=0: single-cycle response and held-request cadence
        wr0 = 1'b1; addr0 = 32'd5; data0 = 32'h12345678;
        tick();
        wr0 = 1'b0;
        chk("l0 wr rdy", 32'(rdy0), 32'd1);
        tick();
        chk("l0 wr idle", 32'(busy0), 32'd0);
        rd0 = 1'b1; addr0 = 32'd5;
        tick();
        chk("l0 rd rdy1", 32'(rdy0), 32'd1);
        chk("l0 rd din", din0, 32'h12345678);
        tick();
        chk("l0 gap", 32'(rdy0), 32'd0);
        tick();
        chk("l0 rd rdy2", 32'(rdy0), 32'd1);
        rd0 = 1'b0;
        tick();
        chk("l0 end", 32'(rdy0), 32'd0);

        // address 0x200 with AW=9: wrap or bounds error
        wr0 = 1'b1; addr0 = 32'd0; data0 = 32'h11;
        tick();
        wr0 = 1'b0;
        tick();
        wr0 = 1'b1; addr0 = 32'h200; data0 = 32'h22;
        tick();
        wr0 = 1'b0;
        chk("oob wr rdy", 32'(rdy0), 32'd1);
        chk("oob wr err", 32'(err0), BOUNDS ? 32'd1 : 32'd0);
        tick();
        chk("oob err clr", 32'(err0), 32'd0);
        rd0 = 1'b1; addr0 = 32'd0;
        tick();
        rd0 = 1'b0;
        chk("rd0 din", din0, BOUNDS ? 32'h11 : 32'h22);
        tick();
        rd0 = 1'b1; addr0 = 32'h200;
        tick();
        rd0 = 1'b0;
        chk("oob rd din", din0, BOUNDS ? 32'h0 : 32'h22);
        chk("oob rd err", 32'(err0), BOUNDS ? 32'd1 : 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
